// File: rtl/user_clk_pkg.sv
// Shared state type and ratio constants for the user clock sequencer.
package user_clk_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int HALF_2MHZ = 25;
  localparam int HALF_4MHZ = 12;

  typedef enum logic [2:0] {STOP, RUN, DRAIN, LOAD, RSTP} state_t;

endpackage

// File: rtl/user_clk_div.sv
// Programmable 50% duty divider: phase counter 0..2*half-1 and registered clock output.
module user_clk_div
  import user_clk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] half,
  output logic             wrap,
  output logic             user_clk
);

  logic [DIV_W:0] cnt;
  logic [DIV_W:0] cnt_next;
  logic [DIV_W:0] last;

  assign last = {half, 1'b0} - (DIV_W+1)'(1);
  assign wrap = run && (cnt == last);

  always_comb begin
    cnt_next = '0;
    if (run && !wrap) begin
      cnt_next = cnt + (DIV_W+1)'(1);
    end
  end

  // The clock is derived from the next count so it stays aligned with cnt.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt      <= '0;
      user_clk <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      user_clk <= run && (cnt_next >= {1'b0, half});
    end
  end

endmodule

// File: rtl/user_clk_seq_ctrl.sv
// Glitch-free reconfiguration sequencer for a fabric user clock and its reset.
// Defining USER_CLK_CNT_EN adds CLK_CNT_OUT, a count of user clock rising edges.
module user_clk_seq_ctrl
  import user_clk_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEF_HALF    = HALF_2MHZ,
  parameter bit DEF_EN      = 1'b1,
  parameter int RST_PERIODS = 5
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic             CFG_VALID_IN,
  output logic             CFG_READY_OUT,
  input  logic [DIV_W-1:0] CFG_HALF_IN,
  input  logic             CFG_ENABLE_IN,
  output logic             CFG_ERR_OUT,
  output logic             USER_CLK_OUT,
  output logic             USER_RST_OUT,
  output logic             LOCKED_OUT
`ifdef USER_CLK_CNT_EN
  ,
  output logic [31:0]      CLK_CNT_OUT
`endif
);

  localparam int RCNT_MAX = RST_PERIODS * 2 * ((1 << DIV_W) - 1);
  localparam int RCNT_W   = $clog2(RCNT_MAX + 1);

  state_t             state;
  state_t             state_next;
  logic [DIV_W-1:0]   active_half;
  logic [DIV_W-1:0]   pend_half;
  logic               pend_en;
  logic [RCNT_W-1:0]  rcnt;
  logic [RCNT_W-1:0]  rst_last;
  logic               ready_hold;
  logic               err;
  logic               rst_out;
  logic               locked;
  logic               xfer;
  logic               bad;
  logic               accept;
  logic               wrap;
  logic               div_run;
  logic               div_load;

  assign CFG_READY_OUT = (state == STOP || state == RUN) && !ready_hold && !RST_IN;
  assign xfer          = CFG_VALID_IN && CFG_READY_OUT;
  assign bad           = (CFG_HALF_IN == '0) && CFG_ENABLE_IN;
  assign accept        = xfer && !bad;
  assign div_run       = (state == RUN) || (state == DRAIN) || (state == RSTP);
  assign div_load      = (state == LOAD);
  assign rst_last      = RCNT_W'(RST_PERIODS * 2 * int'(active_half) - 1);

  assign CFG_ERR_OUT   = err;
  assign USER_RST_OUT  = rst_out;
  assign LOCKED_OUT    = locked;

  user_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk      (CLK_IN),
    .rst      (RST_IN),
    .run      (div_run),
    .load     (div_load),
    .half     (active_half),
    .wrap     (wrap),
    .user_clk (USER_CLK_OUT)
  );

  always_comb begin
    state_next = state;
    case (state)
      STOP:    if (accept) state_next = LOAD;
      RUN:     if (accept) state_next = DRAIN;
      DRAIN:   if (wrap) state_next = LOAD;
      LOAD:    state_next = pend_en ? RSTP : STOP;
      RSTP:    if (rcnt == rst_last) state_next = RUN;
      default: state_next = STOP;
    endcase
  end

  // Reset and lock are registered from the next state so they move with the divider.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state       <= DEF_EN ? RSTP : STOP;
      active_half <= DIV_W'(DEF_HALF);
      pend_half   <= DIV_W'(DEF_HALF);
      pend_en     <= DEF_EN;
      rcnt        <= '0;
      ready_hold  <= 1'b1;
      err         <= 1'b0;
      rst_out     <= 1'b1;
      locked      <= 1'b0;
    end else begin
      state      <= state_next;
      ready_hold <= 1'b0;
      err        <= xfer && bad;
      if (accept) begin
        pend_half <= CFG_HALF_IN;
        pend_en   <= CFG_ENABLE_IN;
      end
      if (state == LOAD) begin
        active_half <= pend_half;
      end
      rcnt    <= (state == RSTP && state_next == RSTP) ? rcnt + RCNT_W'(1) : '0;
      rst_out <= (state_next == RSTP) || (state_next == STOP);
      locked  <= (state_next == RUN);
    end
  end

`ifdef USER_CLK_CNT_EN
  logic        clk_prev;
  logic [31:0] clk_cnt;

  always_ff @(posedge CLK_IN) begin
    if (RST_IN || state == LOAD) begin
      clk_prev <= 1'b0;
      clk_cnt  <= '0;
    end else begin
      clk_prev <= USER_CLK_OUT;
      if (USER_CLK_OUT && !clk_prev) begin
        clk_cnt <= clk_cnt + 32'd1;
      end
    end
  end

  assign CLK_CNT_OUT = clk_cnt;
`endif

endmodule

// File: tb/tb_user_clk_seq_ctrl.sv
// Directed self-checking bench for user_clk_seq_ctrl with default parameters.
// Build with USER_CLK_CNT_EN defined to also exercise the edge counter.
module tb_user_clk_seq_ctrl;
  import user_clk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_half;
  logic       cfg_enable;
  logic       cfg_err;
  logic       user_clk;
  logic       user_rst;
  logic       locked;
`ifdef USER_CLK_CNT_EN
  logic [31:0] clk_cnt;
`endif

  int errors = 0;
  int checks = 0;

  user_clk_seq_ctrl dut (
    .CLK_IN        (clk),
    .RST_IN        (rst),
    .CFG_VALID_IN  (cfg_valid),
    .CFG_READY_OUT (cfg_ready),
    .CFG_HALF_IN   (cfg_half),
    .CFG_ENABLE_IN (cfg_enable),
    .CFG_ERR_OUT   (cfg_err),
    .USER_CLK_OUT  (user_clk),
    .USER_RST_OUT  (user_rst),
    .LOCKED_OUT    (locked)
`ifdef USER_CLK_CNT_EN
    ,
    .CLK_CNT_OUT   (clk_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int half, input logic en);
    cfg_half   = 8'(half);
    cfg_enable = en;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_level(input logic lvl);
    int n = 0;
    while (user_clk !== lvl && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check_output("wait_clk_timeout", 0, 1);
  endtask

  task automatic count_reset(output int n);
    n = 0;
    while (user_rst === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic measure_clock(output int high, output int period);
    int n = 0;
    high = -1;
    period = -1;
    while (user_clk !== 1'b0 && n < 2000) begin tick(); n++; end
    while (user_clk !== 1'b1 && n < 2000) begin tick(); n++; end
    if (n >= 2000) return;
    high = 0;
    while (user_clk === 1'b1 && n < 2000) begin high++; tick(); n++; end
    period = high;
    while (user_clk === 1'b0 && n < 2000) begin period++; tick(); n++; end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_clk"}, user_clk, 0);
    check_output({tag, "_rst"}, user_rst, 1);
    check_output({tag, "_locked"}, locked, 0);
    check_output({tag, "_ready"}, cfg_ready, 0);
    check_output({tag, "_err"}, cfg_err, 0);
  endtask

  initial begin
    int n, hi, period, pre, last_clk, first_rise;
`ifdef USER_CLK_CNT_EN
    longint c0;
`endif
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_half   = '0;
    cfg_enable = 1'b0;

    // Reset values while reset is held and in the first cycle after release.
    tick();
    check_reset_values("rst_hold");
    tick();
    rst = 1'b0;
    check_reset_values("rst_after");

    n = 0;
    first_rise = -1;
    while (user_rst === 1'b1 && n < 5000) begin
      if (user_clk === 1'b1 && first_rise < 0) first_rise = n;
      n++;
      tick();
    end
    check_output("boot_rst_len", n, 250);
    check_output("boot_first_rise", first_rise, HALF_2MHZ);
    check_output("boot_locked", locked, 1);
    check_output("boot_clk_at_release", user_clk, 0);
    measure_clock(hi, period);
    check_output("boot_high", hi, 25);
    check_output("boot_period", period, 50);

    // Reconfigure to the faster ratio from the middle of a high phase.
    wait_level(1'b0);
    wait_level(1'b1);
    hi = 1;
    repeat (5) begin
      tick();
      hi += int'(user_clk);
    end
    check_output("run_ready", cfg_ready, 1);
    apply_stimulus(HALF_4MHZ, 1'b1);
    check_output("drain_locked", locked, 0);
    check_output("drain_ready", cfg_ready, 0);
    pre = 0;
    last_clk = 1;
    n = 0;
    while (user_rst === 1'b0 && n < 1000) begin
      pre++;
      hi += int'(user_clk);
      last_clk = int'(user_clk);
      tick();
      n++;
    end
    check_output("drain_high_phase", hi, 25);
    check_output("drain_plus_load", pre, 20);
    check_output("load_clk_low", last_clk, 0);
    count_reset(n);
    check_output("fast_rst_len", n, 120);
    check_output("fast_locked", locked, 1);
    measure_clock(hi, period);
    check_output("fast_high", hi, 12);
    check_output("fast_period", period, 24);

    // A zero half-period with enable set is rejected without disturbing RUN.
    apply_stimulus(0, 1'b1);
    check_output("bad_err_pulse", cfg_err, 1);
    check_output("bad_locked", locked, 1);
    check_output("bad_ready", cfg_ready, 1);
    tick();
    check_output("bad_err_single", cfg_err, 0);
    measure_clock(hi, period);
    check_output("bad_period", period, 24);

    // Disable: clock finishes its period and parks low in STOP.
    apply_stimulus(HALF_2MHZ, 1'b0);
    n = 0;
    while (cfg_ready !== 1'b1 && n < 200) begin tick(); n++; end
    check_output("stop_ready", cfg_ready, 1);
    check_output("stop_clk", user_clk, 0);
    check_output("stop_rst", user_rst, 1);
    check_output("stop_locked", locked, 0);
    hi = 0;
    repeat (30) begin
      tick();
      hi += int'(user_clk);
    end
    check_output("stop_no_clock", hi, 0);

    // Disable again from STOP, then re-enable at the default ratio.
    apply_stimulus(7, 1'b0);
    check_output("stop_load_ready", cfg_ready, 0);
    tick();
    check_output("stop_back_ready", cfg_ready, 1);
    check_output("stop_back_rst", user_rst, 1);
    apply_stimulus(HALF_2MHZ, 1'b1);
    n = 0;
    while (locked !== 1'b1 && n < 1000) begin n++; tick(); end
    check_output("start_latency", n, 251);
    measure_clock(hi, period);
    check_output("start_period", period, 50);

    // Reset during DRAIN discards the pending ratio.
    apply_stimulus(HALF_4MHZ, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_drain");
    count_reset(n);
    check_output("rst_drain_len", n, 250);
    measure_clock(hi, period);
    check_output("rst_drain_period", period, 50);

    // Reset during RSTP discards the new ratio as well.
    apply_stimulus(HALF_4MHZ, 1'b1);
    n = 0;
    while (user_rst !== 1'b1 && n < 200) begin tick(); n++; end
    check_output("rstp_entered", user_rst, 1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_rstp");
    count_reset(n);
    check_output("rst_rstp_len", n, 250);
    check_output("rst_rstp_locked", locked, 1);
    measure_clock(hi, period);
    check_output("rst_rstp_period", period, 50);

`ifdef USER_CLK_CNT_EN
    // Any 500-cycle window in RUN at half=25 holds exactly ten rising edges.
    c0 = longint'(clk_cnt);
    repeat (500) tick();
    check_output("cnt_ten_periods", longint'(clk_cnt) - c0, 10);
    apply_stimulus(HALF_2MHZ, 1'b1);
    n = 0;
    while (user_rst !== 1'b1 && n < 200) begin tick(); n++; end
    check_output("cnt_cleared_by_load", clk_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_clk_seq_ctrl.md
# user_clk_seq_ctrl

Runtime controller for the fabric-generated user clocks derived from the 100 MHz system clock. It owns one programmable divider and sequences every reconfiguration: it accepts a new half-period or enable setting over a valid/ready handshake and drains the current period so the output never glitches. It then loads the new ratio and issues a user-domain reset lasting a fixed number of new-clock periods before declaring lock. Downstream user logic consumes `USER_CLK_OUT` and `USER_RST_OUT` exactly as it consumes the fixed 2 MHz and 4 MHz user clocks today.

## Interface
- `DIV_W`, 8: width of the half-period field.
- `DEF_HALF`, 25: half-period in `CLK_IN` cycles loaded at reset; 25 gives 2 MHz.
- `DEF_EN`, 1: clock enabled after reset.
- `RST_PERIODS`, 5: length of the user reset, in user-clock periods.
- `CLK_IN` input 1: 100 MHz clock. Single clock; all logic is on its rising edge.
- `RST_IN` input 1: reset, synchronous, active-high.
- `CFG_VALID_IN` input 1: a configuration word is presented.
- `CFG_READY_OUT` output 1: controller can accept configuration.
- `CFG_HALF_IN` input DIV_W: requested half-period.
- `CFG_ENABLE_IN` input 1: 1 means run the clock; 0 means stop it.
- `CFG_ERR_OUT` output 1: one-cycle pulse when a configuration is rejected.
- `USER_CLK_OUT` output 1: generated user clock, registered.
- `USER_RST_OUT` output 1: user-domain reset, active-high, registered.
- `LOCKED_OUT` output 1: clock is running at the configured ratio and reset is released.

## Operation
- The divider phase counter `cnt` runs 0..2·half−1.
  - `USER_CLK_OUT` is 0 while cnt < half and 1 otherwise.
  - Period is 2·half cycles with 50 % duty.
- States:
  - STOP: counter held at 0, clock low, reset high, ready=1.
  - RUN: divider runs, reset low, locked=1, ready=1.
  - DRAIN: divider runs, ready=0.
  - LOAD: one cycle, clock low, ready=0.
  - RSTP: divider runs, reset high, ready=0.
- A transfer occurs when `CFG_VALID_IN`&&`CFG_READY_OUT`. The word is latched into a pending register.
- `CFG_HALF_IN`==0 with `CFG_ENABLE_IN`=1 is rejected:
  - `CFG_ERR_OUT` pulses on the next cycle.
  - State and ratio are unchanged.
  - `LOCKED_OUT` is unaffected.
- Accepted in RUN: go to DRAIN and drop `LOCKED_OUT` the next cycle. DRAIN exits to LOAD on the cycle cnt wraps to 0, so the clock ends low after a complete high phase.
- Accepted in STOP: go directly to LOAD.
- LOAD latches the pending half into the active register and sets cnt=0.
  - If enable=1, next state is RSTP.
  - If enable=0, next state is STOP.
- RSTP holds `USER_RST_OUT`=1 for exactly RST_PERIODS·2·half cycles, then goes to RUN. `USER_RST_OUT` falls coincident with a clock falling edge (cnt=0).
- A configuration identical to the active one is still fully re-sequenced, including drain and reset.
- `CFG_ENABLE_IN`=0 in STOP is accepted and has no effect beyond the LOAD cycle.

## Timing
- Values while and one cycle after `RST_IN`:
  - `USER_CLK_OUT`=0, `USER_RST_OUT`=1, `LOCKED_OUT`=0, `CFG_READY_OUT`=0, `CFG_ERR_OUT`=0.
  - Active half=DEF_HALF.
  - State is RSTP if DEF_EN, else STOP.
- First cycle after `RST_IN` falls has cnt=0.
  - With defaults, `USER_RST_OUT` stays high for exactly 250 cycles.
  - `LOCKED_OUT` rises in the same cycle `USER_RST_OUT` falls.
- Reconfiguration latency from accept to `LOCKED_OUT`:
  - Minimum is 1 + 1 + RST_PERIODS·2·half_new cycles.
  - Maximum adds 2·half_old−1 cycles of drain.
- `RST_IN` asserted in any state aborts the sequence and discards the pending word; the reset values above apply on the next edge.
- Arithmetic: the reset counter is sized for RST_PERIODS·2·(2^DIV_W−1) with no overflow. cnt is DIV_W+1 bits.

## Configuration
- `USER_CLK_CNT_EN` defined:
  - Adds output `CLK_CNT_OUT` [31:0], counting `USER_CLK_OUT` rising edges.
  - Cleared in LOAD and on `RST_IN`; wraps at 2^32.
- `USER_CLK_CNT_EN` undefined: the port and counter do not exist.

## Structure
- Package `user_clk_pkg`:
  - State enum (STOP, RUN, DRAIN, LOAD, RSTP).
  - DIV_W default and default half-periods for 2 MHz (25) and 4 MHz-equivalent (12) ratios.
- Sub-module `user_clk_div`: phase counter plus registered clock output. It takes `run`, `load`, `half` and returns a `wrap` strobe.
- FSM, handshake and reset counter stay in the top.

## Test plan
- Reset release with defaults:
  - `USER_RST_OUT` high 250 cycles, then low with `LOCKED_OUT`=1.
  - `USER_CLK_OUT` period 50, first rise 25 cycles after release.
- In RUN, write half=12, enable=1 mid-high-phase:
  - No clock pulse shorter than 25 cycles.
  - One LOAD cycle low.
  - Reset high for 120 cycles.
  - Period becomes 24.
- Write enable=0: clock stops low after completing its period, `USER_RST_OUT`=1, `LOCKED_OUT`=0, `CFG_READY_OUT`=1.
- Write half=0, enable=1 in RUN: `CFG_ERR_OUT` single pulse, period unchanged, `LOCKED_OUT` stays 1.
- Assert `RST_IN` during DRAIN and again during RSTP: the reset values apply next cycle, the pending ratio is ignored, and the default 250-cycle sequence repeats.
- With `USER_CLK_CNT_EN`: after 10 periods in RUN, `CLK_CNT_OUT` advances by 10; it reads 0 after the next LOAD.
